// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MUL_WAIT/MEM/WB/TRAP sequencer.
// Optional memory-wait timeout trap enabled by defining MEM_TIMEOUT_EN.
module controle_multiciclo #(
  parameter int unsigned MUL_LAT     = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       c_ir_write,
  output logic       c_pc_write,
  output logic [1:0] c_ALUOp,
  output logic       c_fonte_ula,
  output logic [2:0] c_desvio,
  output logic [1:0] c_memoria,
  output logic       c_memtoreg,
  output logic       c_escrever_reg,
  output logic       c_reg_destino,
  output logic       c_jal,
  output logic [2:0] estado,
  output logic       instr_done,
  output logic       erro_ilegal,
  output logic       erro_timeout
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExec    = 3'd2,
    StMulWait = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StTrap    = 3'd6
  } state_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpMul   = 6'b011100;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam int unsigned MulW    = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;
  localparam int unsigned MulLast = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  state_t          state_q, state_d;
  logic [5:0]      op_q, fn_q;
  logic            settle_q;
  logic [MulW-1:0] mul_cnt_q;
  logic            erro_ilegal_q;
  logic            wait_expired;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  logic [WaitW-1:0] wait_cnt_q;
  logic             erro_timeout_q;
  assign wait_expired = (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1));
`else
  assign wait_expired = 1'b0;
`endif

  // Next-state decode. settle_q holds FETCH idle for one cycle after reset so
  // no PC/IR write can follow reset immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (enable && !settle_q) begin
          if (mem_ready)         state_d = StDecode;
          else if (wait_expired) state_d = StTrap;
        end
      end
      StDecode: begin
        case (opcode)
          OpJ, OpJal:                           state_d = StFetch;
          OpRtype:                              state_d = (funct == FnJr) ? StFetch : StExec;
          OpMul, OpLw, OpSw, OpAddi, OpBeq, OpBne: state_d = StExec;
          default:                              state_d = StTrap;
        endcase
      end
      StExec: begin
        case (op_q)
          // jr never reaches EXEC; treat a stray one as finished.
          OpRtype:    state_d = (fn_q == FnJr) ? StFetch : StWb;
          OpAddi:     state_d = StWb;
          OpMul:      state_d = (MUL_LAT > 1) ? StMulWait : StWb;
          OpLw, OpSw: state_d = StMem;
          default:    state_d = StFetch;
        endcase
      end
      StMulWait: begin
        if (mul_cnt_q == MulW'(MulLast)) state_d = StWb;
      end
      StMem: begin
        if (mem_ready)         state_d = (op_q == OpSw) ? StFetch : StWb;
        else if (wait_expired) state_d = StTrap;
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= StFetch;
      op_q          <= '0;
      fn_q          <= '0;
      settle_q      <= 1'b1;
      mul_cnt_q     <= '0;
      erro_ilegal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q     <= '0;
      erro_timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= 1'b0;
      if (state_q == StDecode) begin
        op_q <= opcode;
        fn_q <= funct;
        if (state_d == StTrap) erro_ilegal_q <= 1'b1;
      end
      if (state_q == StMulWait) mul_cnt_q <= mul_cnt_q + 1'b1;
      else                      mul_cnt_q <= '0;
`ifdef MEM_TIMEOUT_EN
      if (state_d != state_q && (state_d == StFetch || state_d == StMem)) begin
        wait_cnt_q <= '0;
      end else if (state_q == StFetch && enable && !settle_q && !mem_ready) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else if (state_q == StMem && !mem_ready) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (state_d == StTrap && (state_q == StFetch || state_q == StMem)) begin
        erro_timeout_q <= 1'b1;
      end
`endif
    end
  end

  // Moore decode from state and latched opcode; everything forced low in reset.
  always_comb begin
    c_ir_write     = 1'b0;
    c_pc_write     = 1'b0;
    c_ALUOp        = 2'b00;
    c_fonte_ula    = 1'b0;
    c_desvio       = 3'b000;
    c_memoria      = 2'b00;
    c_memtoreg     = 1'b0;
    c_escrever_reg = 1'b0;
    c_reg_destino  = 1'b0;
    c_jal          = 1'b0;
    instr_done     = 1'b0;
    estado         = 3'd0;
    if (reset_n) begin
      estado = state_q;
      case (state_q)
        StFetch: begin
          if (enable && !settle_q) begin
            c_memoria = 2'b01;
            if (mem_ready) begin
              c_ir_write = 1'b1;
              c_pc_write = 1'b1;
            end
          end
        end
        StDecode: begin
          case (opcode)
            OpJ: begin
              c_desvio   = 3'b011;
              c_pc_write = 1'b1;
              instr_done = 1'b1;
            end
            OpJal: begin
              c_desvio       = 3'b100;
              c_pc_write     = 1'b1;
              c_escrever_reg = 1'b1;
              c_jal          = 1'b1;
              instr_done     = 1'b1;
            end
            OpRtype: begin
              if (funct == FnJr) begin
                c_desvio   = 3'b101;
                c_ALUOp    = 2'b01;
                c_pc_write = 1'b1;
                instr_done = 1'b1;
              end
            end
            default: ;
          endcase
        end
        StExec: begin
          case (op_q)
            OpRtype, OpMul: c_ALUOp = 2'b10;
            OpAddi, OpLw, OpSw: c_fonte_ula = 1'b1;
            OpBeq: begin
              c_ALUOp    = 2'b01;
              c_desvio   = 3'b001;
              c_pc_write = zero;
              instr_done = 1'b1;
            end
            OpBne: begin
              c_ALUOp    = 2'b01;
              c_desvio   = 3'b010;
              c_pc_write = !zero;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        StMulWait: c_ALUOp = 2'b10;
        StMem: begin
          c_memoria  = (op_q == OpSw) ? 2'b10 : 2'b01;
          instr_done = mem_ready && (op_q == OpSw);
        end
        StWb: begin
          c_escrever_reg = 1'b1;
          c_reg_destino  = (op_q == OpRtype) || (op_q == OpMul);
          c_memtoreg     = (op_q == OpLw);
          instr_done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign erro_ilegal = reset_n && erro_ilegal_q;
`ifdef MEM_TIMEOUT_EN
  assign erro_timeout = reset_n && erro_timeout_q;
`else
  assign erro_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed cycle-by-cycle bench for controle_multiciclo (default MUL_LAT=3, MEM_TIMEOUT=15).
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset_n, enable, mem_ready, zero;
  logic [5:0] opcode, funct;
  logic       c_ir_write, c_pc_write, c_fonte_ula, c_memtoreg, c_escrever_reg;
  logic       c_reg_destino, c_jal, instr_done, erro_ilegal, erro_timeout;
  logic [1:0] c_ALUOp, c_memoria;
  logic [2:0] c_desvio, estado;
  logic [17:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  controle_multiciclo dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .opcode         (opcode),
    .funct          (funct),
    .mem_ready      (mem_ready),
    .zero           (zero),
    .c_ir_write     (c_ir_write),
    .c_pc_write     (c_pc_write),
    .c_ALUOp        (c_ALUOp),
    .c_fonte_ula    (c_fonte_ula),
    .c_desvio       (c_desvio),
    .c_memoria      (c_memoria),
    .c_memtoreg     (c_memtoreg),
    .c_escrever_reg (c_escrever_reg),
    .c_reg_destino  (c_reg_destino),
    .c_jal          (c_jal),
    .estado         (estado),
    .instr_done     (instr_done),
    .erro_ilegal    (erro_ilegal),
    .erro_timeout   (erro_timeout)
  );

  assign obs = {c_ir_write, c_pc_write, c_ALUOp, c_fonte_ula, c_desvio, c_memoria, c_memtoreg,
                c_escrever_reg, c_reg_destino, c_jal, estado, instr_done};

  function automatic logic [17:0] cv(input logic ir, input logic pc, input logic [1:0] alu,
                                     input logic fu, input logic [2:0] des,
                                     input logic [1:0] mem, input logic m2r, input logic wr,
                                     input logic rd, input logic jal, input logic [2:0] st,
                                     input logic done);
    return {ir, pc, alu, fu, des, mem, m2r, wr, rd, jal, st, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, advance past the next edge.
  task automatic cyc(input string tag, input logic en, input logic rdy, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic [17:0] exp);
    enable    = en;
    mem_ready = rdy;
    opcode    = op;
    funct     = fn;
    zero      = z;
    #2;
    check(tag, 32'(obs), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc(tag, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, cv(1, 1, 2'b00, 0, 3'd0, 2'b01, 0, 0, 0, 0, 3'd0, 0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc("rst", 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 18'd0);
    reset_n = 1'b1;
    cyc("settle", 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 18'd0);
  endtask

  localparam logic [17:0] Dec0 = 18'h00002;  // estado=1, nothing else

  initial begin
    reset_n = 1'b0; enable = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    opcode = '0; funct = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    cyc("rst_outs", 1'b1, 1'b1, 6'h3f, 6'h3f, 1'b1, 18'd0);
    check("rst_ilegal", 32'(erro_ilegal), 32'd0);
    check("rst_timeout", 32'(erro_timeout), 32'd0);
    reset_n = 1'b1;
    cyc("settle", 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 18'd0);

    // add, with opcode input disturbed during EXEC to prove the latch is used
    fetch("add_f");
    cyc("add_d", 1, 0, 6'h00, 6'h20, 0, Dec0);
    cyc("add_e", 1, 1, 6'h23, 6'h00, 0, cv(0, 0, 2'b10, 0, 3'd0, 2'b00, 0, 0, 0, 0, 3'd2, 0));
    cyc("add_wb", 1, 1, 6'h23, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b00, 0, 1, 1, 0, 3'd5, 1));

    cyc("idle0", 0, 1, 6'h00, 6'h00, 0, 18'd0);
    cyc("idle1", 0, 1, 6'h00, 6'h00, 0, 18'd0);

    // lw with two wait cycles in MEM
    fetch("lw_f");
    cyc("lw_d", 1, 0, 6'h23, 6'h00, 0, Dec0);
    cyc("lw_e", 1, 0, 6'h23, 6'h00, 0, cv(0, 0, 2'b00, 1, 3'd0, 2'b00, 0, 0, 0, 0, 3'd2, 0));
    cyc("lw_m0", 1, 0, 6'h23, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b01, 0, 0, 0, 0, 3'd4, 0));
    cyc("lw_m1", 1, 0, 6'h23, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b01, 0, 0, 0, 0, 3'd4, 0));
    cyc("lw_m2", 1, 1, 6'h23, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b01, 0, 0, 0, 0, 3'd4, 0));
    cyc("lw_wb", 1, 1, 6'h23, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b00, 1, 1, 0, 0, 3'd5, 1));

    // branches
    fetch("beq1_f");
    cyc("beq1_d", 1, 1, 6'h04, 6'h00, 0, Dec0);
    cyc("beq1_e", 1, 1, 6'h04, 6'h00, 1, cv(0, 1, 2'b01, 0, 3'd1, 2'b00, 0, 0, 0, 0, 3'd2, 1));
    fetch("beq0_f");
    cyc("beq0_d", 1, 1, 6'h04, 6'h00, 0, Dec0);
    cyc("beq0_e", 1, 1, 6'h04, 6'h00, 0, cv(0, 0, 2'b01, 0, 3'd1, 2'b00, 0, 0, 0, 0, 3'd2, 1));
    fetch("bne_f");
    cyc("bne_d", 1, 1, 6'h05, 6'h00, 0, Dec0);
    cyc("bne_e", 1, 1, 6'h05, 6'h00, 0, cv(0, 1, 2'b01, 0, 3'd2, 2'b00, 0, 0, 0, 0, 3'd2, 1));

    // mul: two MUL_WAIT cycles
    fetch("mul_f");
    cyc("mul_d", 1, 1, 6'h1c, 6'h02, 0, Dec0);
    cyc("mul_e", 1, 1, 6'h1c, 6'h02, 0, cv(0, 0, 2'b10, 0, 3'd0, 2'b00, 0, 0, 0, 0, 3'd2, 0));
    cyc("mul_w0", 1, 1, 6'h1c, 6'h02, 0, cv(0, 0, 2'b10, 0, 3'd0, 2'b00, 0, 0, 0, 0, 3'd3, 0));
    cyc("mul_w1", 1, 1, 6'h1c, 6'h02, 0, cv(0, 0, 2'b10, 0, 3'd0, 2'b00, 0, 0, 0, 0, 3'd3, 0));
    cyc("mul_wb", 1, 1, 6'h1c, 6'h02, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b00, 0, 1, 1, 0, 3'd5, 1));

    // jumps resolved in DECODE
    fetch("jal_f");
    cyc("jal_d", 1, 1, 6'h03, 6'h00, 0, cv(0, 1, 2'b00, 0, 3'd4, 2'b00, 0, 1, 0, 1, 3'd1, 1));
    fetch("j_f");
    cyc("j_d", 1, 1, 6'h02, 6'h00, 0, cv(0, 1, 2'b00, 0, 3'd3, 2'b00, 0, 0, 0, 0, 3'd1, 1));
    fetch("jr_f");
    cyc("jr_d", 1, 1, 6'h00, 6'h08, 0, cv(0, 1, 2'b01, 0, 3'd5, 2'b00, 0, 0, 0, 0, 3'd1, 1));

    // addi whose low bits happen to look like jr
    fetch("addi_f");
    cyc("addi_d", 1, 1, 6'h08, 6'h08, 0, Dec0);
    cyc("addi_e", 1, 1, 6'h08, 6'h08, 0, cv(0, 0, 2'b00, 1, 3'd0, 2'b00, 0, 0, 0, 0, 3'd2, 0));
    cyc("addi_wb", 1, 1, 6'h08, 6'h08, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b00, 0, 1, 0, 0, 3'd5, 1));

    // sw aborted by reset in MEM, then a clean sw
    fetch("sw_f");
    cyc("sw_d", 1, 1, 6'h2b, 6'h00, 0, Dec0);
    cyc("sw_e", 1, 1, 6'h2b, 6'h00, 0, cv(0, 0, 2'b00, 1, 3'd0, 2'b00, 0, 0, 0, 0, 3'd2, 0));
    cyc("sw_m0", 1, 0, 6'h2b, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b10, 0, 0, 0, 0, 3'd4, 0));
    reset_n = 1'b0;
    cyc("sw_rst", 1, 1, 6'h2b, 6'h00, 0, 18'd0);
    reset_n = 1'b1;
    cyc("sw_post", 1, 1, 6'h2b, 6'h00, 0, 18'd0);
    fetch("sw2_f");
    cyc("sw2_d", 1, 1, 6'h2b, 6'h00, 0, Dec0);
    cyc("sw2_e", 1, 1, 6'h2b, 6'h00, 0, cv(0, 0, 2'b00, 1, 3'd0, 2'b00, 0, 0, 0, 0, 3'd2, 0));
    cyc("sw2_m", 1, 1, 6'h2b, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b10, 0, 0, 0, 0, 3'd4, 1));

    // illegal opcode trap
    fetch("ill_f");
    check("ill_pre", 32'(erro_ilegal), 32'd0);
    cyc("ill_d", 1, 1, 6'h3f, 6'h00, 0, Dec0);
    cyc("ill_t0", 1, 1, 6'h00, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b00, 0, 0, 0, 0, 3'd6, 0));
    check("ill_flag", 32'(erro_ilegal), 32'd1);
    cyc("ill_t1", 1, 1, 6'h00, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b00, 0, 0, 0, 0, 3'd6, 0));
    check("ill_sticky", 32'(erro_ilegal), 32'd1);
    check("ill_tmo", 32'(erro_timeout), 32'd0);
    do_reset();
    check("ill_clr", 32'(erro_ilegal), 32'd0);

`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      cyc("tmo_wait", 1, 0, 6'h00, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b01, 0, 0, 0, 0, 3'd0, 0));
    end
    cyc("tmo_trap", 1, 0, 6'h00, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b00, 0, 0, 0, 0, 3'd6, 0));
    check("tmo_flag", 32'(erro_timeout), 32'd1);
    check("tmo_ilegal", 32'(erro_ilegal), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      cyc("nowait", 1, 0, 6'h00, 6'h00, 0, cv(0, 0, 2'b00, 0, 3'd0, 2'b01, 0, 0, 0, 0, 3'd0, 0));
    end
    check("no_tmo", 32'(erro_timeout), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
